// File: rtl/fftbin_writer_pkg.sv
// fftbin_writer_pkg: shared constants and types for the FFT bin writer.
//   PEQ_DISPLWIDTH    - column height width per channel (fixed at 8)
//   LOG_CODES_PER_OCT - log resolution: 16 codes per octave
//   LOG_MANT_BITS     - mantissa bits taken below the leading one
//   LOG_CLAMP         - largest representable height code
//   frame_state_t     - frame FSM encodings
package fftbin_writer_pkg;

    localparam int PEQ_DISPLWIDTH    = 8;
    localparam int LOG_CODES_PER_OCT = 16;
    localparam int LOG_MANT_BITS     = $clog2(LOG_CODES_PER_OCT);
    localparam int LOG_CLAMP         = 255;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SKIP    = 2'd2
    } frame_state_t;

endpackage

// File: rtl/fftbin_writer_if.sv
// fftbin_writer_if: FFT unload stream in, display RAM write port out.
//   fft_valid/fft_idx/fft{0,1}_{re,im}/hold - one bin per valid cycle
//   wr_en/wr_addr/wr_data/frame_done        - display RAM write strobe
// master = stream source / RAM sink, slave = the writer block.
interface fftbin_writer_if #(
    parameter int LOGFFTSIZE = 12,
    parameter int LOGDSPSIZE = 10,
    parameter int AUDIOWIDTH = 16,
    parameter int DISPLWIDTH = 8
);
    logic                         fft_valid;
    logic [LOGFFTSIZE-1:0]        fft_idx;
    logic signed [AUDIOWIDTH-1:0] fft0_re;
    logic signed [AUDIOWIDTH-1:0] fft0_im;
    logic signed [AUDIOWIDTH-1:0] fft1_re;
    logic signed [AUDIOWIDTH-1:0] fft1_im;
    logic                         hold;
    logic                         wr_en;
    logic [LOGDSPSIZE-1:0]        wr_addr;
    logic [2*DISPLWIDTH-1:0]      wr_data;
    logic                         frame_done;

    modport master (
        output fft_valid, fft_idx, fft0_re, fft0_im, fft1_re, fft1_im, hold,
        input  wr_en, wr_addr, wr_data, frame_done
    );

    modport slave (
        input  fft_valid, fft_idx, fft0_re, fft0_im, fft1_re, fft1_im, hold,
        output wr_en, wr_addr, wr_data, frame_done
    );
endinterface

// File: rtl/fftbin_writer_logmag.sv
// logmag8: one channel of |z| -> 8-bit log height, three register stages.
//   clk, rst - clock, async active-high reset
//   re, im   - signed bin value (registered upstream)
//   height   - log height, valid three clocks after re/im
// Stage 1: |re|, |im|. Stage 2: max + min/2. Stage 3: 16*p + 4 bits below p.
module logmag8
    import fftbin_writer_pkg::*;
#(
    parameter int AUDIOWIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [AUDIOWIDTH-1:0] re,
    input  logic signed [AUDIOWIDTH-1:0] im,
    output logic [PEQ_DISPLWIDTH-1:0]    height
);
    localparam int MW = AUDIOWIDTH + 1;       // magnitude width
    localparam int PW = $clog2(MW);           // leading-one position width
    localparam int CW = PW + LOG_MANT_BITS;   // unclamped code width
    localparam logic [AUDIOWIDTH-1:0] ONE = {{(AUDIOWIDTH-1){1'b0}}, 1'b1};

    logic [AUDIOWIDTH-1:0]     ure, uim, abs_re_c, abs_im_c;
    logic [AUDIOWIDTH-1:0]     abs_re_q, abs_im_q;
    logic [AUDIOWIDTH-1:0]     big_c, small_c;
    logic [MW-1:0]             mag_c, mag_q;
    logic [PW-1:0]             lead_c;
    logic [MW-1:0]             norm_c;
    logic [CW-1:0]             code_c;
    logic [PEQ_DISPLWIDTH-1:0] height_c;

    // Unsigned abs keeps -2^(W-1) exact as 2^(W-1).
    always_comb begin
        ure      = re;
        uim      = im;
        abs_re_c = ure[AUDIOWIDTH-1] ? (~ure + ONE) : ure;
        abs_im_c = uim[AUDIOWIDTH-1] ? (~uim + ONE) : uim;
    end

    always_comb begin
        big_c   = (abs_re_q >= abs_im_q) ? abs_re_q : abs_im_q;
        small_c = (abs_re_q >= abs_im_q) ? abs_im_q : abs_re_q;
        mag_c   = {1'b0, big_c} + {2'b00, small_c[AUDIOWIDTH-1:1]};
    end

    // Zero magnitude falls out as code 0: lead=0 and the left shift clears it.
    always_comb begin
        lead_c = '0;
        for (int i = 0; i < MW; i++)
            if (mag_q[i]) lead_c = PW'(i);
        if (lead_c >= PW'(LOG_MANT_BITS))
            norm_c = mag_q >> (lead_c - PW'(LOG_MANT_BITS));
        else
            norm_c = mag_q << (PW'(LOG_MANT_BITS) - lead_c);
        code_c   = {lead_c, norm_c[LOG_MANT_BITS-1:0]};
        height_c = (code_c > CW'(LOG_CLAMP)) ? PEQ_DISPLWIDTH'(LOG_CLAMP)
                                             : code_c[PEQ_DISPLWIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abs_re_q <= '0;
            abs_im_q <= '0;
            mag_q    <= '0;
            height   <= '0;
        end else begin
            abs_re_q <= abs_re_c;
            abs_im_q <= abs_im_c;
            mag_q    <= mag_c;
            height   <= height_c;
        end
    end
endmodule

// File: rtl/fftbin_writer.sv
// fftbin_writer: two-channel FFT bins -> log column heights -> display RAM.
//   clk, rst - clock, async active-high reset
//   bus      - slave side: FFT stream in, RAM write port out
// Pipeline: input/FSM tag -> abs -> mag -> log -> group max / write.
// A write {max0, max1} is issued on the last bin of each group of G bins.
module fftbin_writer
    import fftbin_writer_pkg::*;
#(
    parameter int LOGFFTSIZE = 12,
    parameter int LOGDSPSIZE = 10,
    parameter int AUDIOWIDTH = 16,
    parameter int DISPLWIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    fftbin_writer_if.slave  bus
);
    localparam int NUM_CH    = 2;
    localparam int LOG_LAT   = 3;   // abs, mag, log stages after the input stage
    localparam int HALF_BINS = 2 ** (LOGFFTSIZE - 1);
    localparam int LOGG      = LOGFFTSIZE - 1 - LOGDSPSIZE;
    localparam logic [LOGFFTSIZE-1:0] GRP_MASK = LOGFFTSIZE'((2 ** LOGG) - 1);
    localparam logic [LOGFFTSIZE-1:0] LAST_BIN = LOGFFTSIZE'(HALF_BINS - 1);

    typedef struct packed {
        logic                  first;
        logic                  last;
        logic                  close;
        logic [LOGDSPSIZE-1:0] col;
    } bin_tag_t;

    frame_state_t state;
    logic         idx_zero, accept;
    bin_tag_t     tag_in;

    logic [LOG_LAT:0] vld_pipe;
    bin_tag_t         tag_pipe [LOG_LAT:0];

    logic [NUM_CH-1:0][AUDIOWIDTH-1:0]     ch_re_q, ch_im_q;
    logic [NUM_CH-1:0][PEQ_DISPLWIDTH-1:0] ch_h, acc, nmax;

    logic                    wr_en_q, frame_done_q;
    logic [LOGDSPSIZE-1:0]   wr_addr_q;
    logic [2*DISPLWIDTH-1:0] wr_data_q;

    // idx=0 restarts from any state; other bins count only inside CAPTURE
    // and only from the displayed lower half.
    always_comb begin
        idx_zero     = (bus.fft_idx == '0);
        accept       = bus.fft_valid &&
                       (idx_zero ? !bus.hold
                                 : (state == ST_CAPTURE && !bus.fft_idx[LOGFFTSIZE-1]));
        tag_in.first = ((bus.fft_idx & GRP_MASK) == '0);
        tag_in.last  = ((bus.fft_idx & GRP_MASK) == GRP_MASK);
        tag_in.close = (bus.fft_idx == LAST_BIN);
        tag_in.col   = bus.fft_idx[LOGG +: LOGDSPSIZE];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else if (bus.fft_valid && idx_zero)
            state <= bus.hold ? ST_SKIP : ST_CAPTURE;
        else if (accept && tag_in.close)
            state <= ST_IDLE;
    end

    // Decisions ride with the data, so in-flight bins finish even after
    // the FSM has moved on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int s = 0; s <= LOG_LAT; s++) tag_pipe[s] <= '0;
            ch_re_q  <= '0;
            ch_im_q  <= '0;
        end else begin
            vld_pipe    <= {vld_pipe[LOG_LAT-1:0], accept};
            tag_pipe[0] <= tag_in;
            for (int s = 1; s <= LOG_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
            ch_re_q     <= {bus.fft1_re, bus.fft0_re};
            ch_im_q     <= {bus.fft1_im, bus.fft0_im};
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logmag8 #(.AUDIOWIDTH(AUDIOWIDTH)) u_logmag (
            .clk    (clk),
            .rst    (rst),
            .re     (ch_re_q[c]),
            .im     (ch_im_q[c]),
            .height (ch_h[c])
        );
    end

    // First bin of a group overwrites the running max, which also drops
    // any partial group left by a restart.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++)
            nmax[c] = (tag_pipe[LOG_LAT].first || ch_h[c] > acc[c]) ? ch_h[c] : acc[c];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc          <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            if (vld_pipe[LOG_LAT]) begin
                acc <= nmax;
                if (tag_pipe[LOG_LAT].last) begin
                    wr_en_q      <= 1'b1;
                    wr_addr_q    <= tag_pipe[LOG_LAT].col;
                    wr_data_q    <= {nmax[0], nmax[1]};
                    frame_done_q <= tag_pipe[LOG_LAT].close;
                end
            end
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: doc/fftbin_writer.md
# fftbin_writer

Converts the two-channel FFT output stream into 8-bit log-magnitude column heights and writes them into the write port of the display RAM that the FFT display renderer scans by `hcount`. Sits between the FFT core unload port and the dual-port display buffer. Each display word is `{ch0_height, ch1_height}`: high byte is channel 0 (upper panel), low byte is channel 1 (lower panel). No backpressure; the block keeps pace with the FFT unload rate.

## Interface
- `LOGFFTSIZE`, 12, log2 FFT points; only bins 0..2^(LOGFFTSIZE-1)-1 are displayed
- `LOGDSPSIZE`, 10, log2 display columns; must be ≤ LOGFFTSIZE-1
- `AUDIOWIDTH`, 16, signed width of FFT re/im outputs
- `DISPLWIDTH`, 8, height width per channel; fixed at 8
- `clk` in 1 — sole clock
- `rst` in 1 — asynchronous, active-high reset
- `fft_valid` in 1 — one bin presented this cycle
- `fft_idx` in LOGFFTSIZE — bin index
- `fft0_re`, `fft0_im`, `fft1_re`, `fft1_im` in AUDIOWIDTH each — signed bin values for ch0 and ch1
- `hold` in 1 — freeze display; sampled at bin 0
- `wr_en` out 1 — display RAM write strobe
- `wr_addr` out LOGDSPSIZE — column
- `wr_data` out 2*DISPLWIDTH — `{h0, h1}`
- `frame_done` out 1 — one-cycle pulse, coincident with the last write of a frame

## Operation
- Group size G = 2^(LOGFFTSIZE-1-LOGDSPSIZE); default G=2. Column = fft_idx >> log2(G).
- Magnitude per channel: a=|re|, b=|im| (AUDIOWIDTH bits unsigned, so -2^(W-1) is exact); mag = max(a,b) + (min(a,b)>>1), AUDIOWIDTH+1 bits.
- Log height: mag=0 -> 0; otherwise p = leading-one position, m = the 4 bits below it (zero-padded when p<4); h = min(255, 16*p + m).
- Group reduction: a running max per channel is reset at the first bin of a group (idx low bits = 0) and updated on each later bin. On the last bin (low bits all 1) the block writes `{max0, max1}` to the column.
- Frame FSM: IDLE, CAPTURE, SKIP.
  - IDLE: await valid with idx=0 -> CAPTURE if hold=0, else SKIP.
  - CAPTURE: bins processed. The accepted bin idx = 2^(LOGFFTSIZE-1)-1 closes the frame -> IDLE. Bins ≥ 2^(LOGFFTSIZE-1) are ignored.
  - SKIP: no writes, no frame_done. Leaves only on the next idx=0, re-evaluating hold.
  - Valid with idx=0 in any state restarts the frame: the partial group is discarded, and columns already written stay written.
- `fft_valid` gaps are allowed; pipeline valid bits carry through, and accumulation spans gaps.
- frame_done is asserted only when a frame closes in CAPTURE.

## Timing
- 4 register stages: abs -> mag -> log -> accumulate/output. wr_en rises in the cycle after the 4th clock edge following the edge that sampled the group's last bin.
- wr_en is a single-cycle pulse per column; at most one write per clock. Back-to-back writes occur every G valid bins.
- FSM decisions use the sampled idx/hold at input stage 0. Their effect is tagged through the pipeline, so data already in flight from a closed or restarted frame still completes its write if its group completed.
- Reset (any time): all outputs 0, pipeline valid bits cleared, accumulators 0, FSM=IDLE. A mid-frame reset discards the frame; the display RAM contents are untouched.

## Structure
- Shared package/header: `PEQ_DISPLWIDTH`, log-code constants (16 codes per octave, clamp 255), FSM state encodings.
- Sub-module `logmag8`: combinational/registered abs + alpha-max-beta-min + leading-one log encoder. One instance per channel.

## Test plan
- Reset: assert rst mid-stream -> wr_en, wr_addr, wr_data, frame_done all 0 immediately. No write occurs until a fresh idx=0.
- Tone: full frame of zeros except bin 6, ch0 re=0x4000 im=0, and ch1 re=-3 im=4 -> column 3 written {224, 36}; all other columns {0,0}. frame_done with column 1023's write, exactly 4 cycles after the edge sampling bin 2047.
- Extremes: re=im=-32768 on ch0 at bins 10/11 -> column 5 h0=248. A bin 10 height of 100 and a bin 11 height of 40 -> column stores 100 (group max).
- Hold: hold=1 at idx 0 -> zero writes for that frame. hold=0 at the next idx 0 -> normal 1024 writes.
- Restart: idx 0..700 then idx 0 again -> columns 0..349 written once in the first pass. Bin 700's partial group is dropped, the new frame completes normally, and only one frame_done is emitted.
- Gaps/upper half: random fft_valid deassertion plus bins 2048..4095 presented -> results identical to the gap-free run, and no write with idx ≥ 2048.
